// File: rtl/pingpong_frame_reader_if.sv
// Signal bundle between the ping-pong frame reader, its two BRAM banks and the
// downstream analysis stream. The reader drives through "master"; the environment uses "slave".
interface pingpong_frame_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              wr_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              switch;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              frame_done;
  logic              overrun;

  modport master (
    input  wr_valid, rd_data, out_ready,
    output wr_en, wr_addr, switch, rd_en, rd_addr,
           out_valid, out_data, out_last, frame_done, overrun
  );

  modport slave (
    output wr_valid, rd_data, out_ready,
    input  wr_en, wr_addr, switch, rd_en, rd_addr,
           out_valid, out_data, out_last, frame_done, overrun
  );
endinterface

// File: rtl/pingpong_frame_reader.sv
// Ping-pong ECG buffer controller: addresses the write bank, flips banks on frame
// completion and drains the filled bank through a 2-entry skid FIFO onto a valid/ready stream.
module pingpong_frame_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int FRAME_LEN = 4096
) (
  input logic                     clk,
  input logic                     rst,
  pingpong_frame_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              switch_q;
  logic              overrun_q;
  logic              frame_done_q;
  logic              rd_pending;
  logic              rd_pending_last;
  logic              head_valid;
  logic              head_last;
  logic [DATA_W-1:0] head_data;
  logic              skid_valid;
  logic              skid_last;
  logic [DATA_W-1:0] skid_data;

  logic              frame_complete;
  logic              pop;
  logic              push;
  logic              rd_en;
  logic [1:0]        level;

  assign frame_complete = bus.wr_valid && (wr_addr == LAST_ADDR);
  assign pop            = head_valid && bus.out_ready;
  assign push           = rd_pending;

  // Entries held or still coming back from the BRAM once this cycle's pop is taken
  // out; keeping this below 2 guarantees the skid FIFO can never overflow.
  assign level = {1'b0, head_valid} + {1'b0, skid_valid} + {1'b0, rd_pending} - {1'b0, pop};
  assign rd_en = (state == DRAIN) && (level < 2'd2);

  assign bus.wr_en      = bus.wr_valid;
  assign bus.wr_addr    = wr_addr;
  assign bus.switch     = switch_q;
  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = rd_addr;
  assign bus.out_valid  = head_valid;
  assign bus.out_data   = head_data;
  assign bus.out_last   = head_last;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
    end else if (bus.wr_valid) begin
      wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
    end
  end

  // A completed frame only flips banks when the reader is fully idle; any other
  // state (including the FLUSH->IDLE cycle) loses the new frame and flags overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      switch_q        <= 1'b0;
      overrun_q       <= 1'b0;
      rd_addr         <= '0;
      frame_done_q    <= 1'b0;
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
    end else begin
      frame_done_q    <= 1'b0;
      rd_pending      <= rd_en;
      rd_pending_last <= rd_en && (rd_addr == LAST_ADDR);
      if (frame_complete && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_complete) begin
            switch_q <= ~switch_q;
            rd_addr  <= '0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_en) begin
            if (rd_addr == LAST_ADDR) begin
              rd_addr <= '0;
              state   <= FLUSH;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!head_valid && !skid_valid && !rd_pending) begin
            state        <= IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Head register is the output stage; skid only fills when the head is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_last  <= 1'b0;
      head_data  <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else if (pop) begin
      if (skid_valid) begin
        head_data  <= skid_data;
        head_last  <= skid_last;
        skid_valid <= push;
        if (push) begin
          skid_data <= bus.rd_data;
          skid_last <= rd_pending_last;
        end
      end else begin
        head_valid <= push;
        if (push) begin
          head_data <= bus.rd_data;
          head_last <= rd_pending_last;
        end
      end
    end else if (push) begin
      if (!head_valid) begin
        head_valid <= 1'b1;
        head_data  <= bus.rd_data;
        head_last  <= rd_pending_last;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= bus.rd_data;
        skid_last  <= rd_pending_last;
      end
    end
  end

endmodule
